// File: rtl/vec_pkg.sv
// Shared definitions for the vector datapath: fold op encodings, lane count
// and the reduction FSM state encoding.
package vec_pkg;
    localparam int LANES = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Any encoding with the top bit set is outside the supported op set.
    function automatic logic op_legal(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction
endpackage

// File: rtl/alu.sv
// Scalar ALU: add, sub, and, or with ARM-style {N,Z,C,V} flags.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       ALUControl,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       ALUFlags
);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] b_eff;
    logic             is_arith;

    always_comb begin
        // Subtraction is a + ~b + 1, so carry-out is the inverted borrow.
        b_eff    = ALUControl[0] ? ~b : b;
        sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, ALUControl[0]};
        is_arith = ~ALUControl[1];
        case (ALUControl)
            2'b10:   Result = a & b;
            2'b11:   Result = a | b;
            default: Result = sum[WIDTH-1:0];
        endcase
        ALUFlags[3] = Result[WIDTH-1];
        ALUFlags[2] = (Result == '0);
        ALUFlags[1] = is_arith & sum[WIDTH];
        ALUFlags[0] = is_arith & ~(a[WIDTH-1] ^ b_eff[WIDTH-1]) & (a[WIDTH-1] ^ sum[WIDTH-1]);
    end
endmodule

// File: rtl/vector_reduce.sv
// Sequential 5-lane vector-to-scalar reduction: folds lanes 1..4 into an
// accumulator seeded with lane 0 through one shared ALU, one lane per clock.
module vector_reduce
    import vec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a_0,
    input  logic [WIDTH-1:0] a_1,
    input  logic [WIDTH-1:0] a_2,
    input  logic [WIDTH-1:0] a_3,
    input  logic [WIDTH-1:0] a_4,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             err
);
    // Handshake: start is taken on any edge where busy=0 (IDLE or DONE);
    // done is a one-cycle pulse marking result/flags/err valid.
    logic [1:0]       state;
    logic [2:0]       idx;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] lane_q [1:LANES-1];
    logic [WIDTH-1:0] lane_sel;
    logic [WIDTH-1:0] alu_res;
    logic [3:0]       alu_flags;

    always_comb begin
        case (idx)
            3'd1:    lane_sel = lane_q[1];
            3'd2:    lane_sel = lane_q[2];
            3'd3:    lane_sel = lane_q[3];
            3'd4:    lane_sel = lane_q[4];
            default: lane_sel = '0;
        endcase
    end

    alu #(.WIDTH(WIDTH)) u_alu (
        .a          (acc),
        .b          (lane_sel),
        .ALUControl (op_q[1:0]),
        .Result     (alu_res),
        .ALUFlags   (alu_flags)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            idx    <= '0;
            op_q   <= '0;
            acc    <= '0;
            result <= '0;
            flags  <= '0;
            err    <= 1'b0;
            for (int i = 1; i < LANES; i++) lane_q[i] <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (!op_legal(op_q)) begin
                        result <= '0;
                        flags  <= '0;
                        err    <= 1'b1;
                        idx    <= '0;
                        state  <= ST_DONE;
                    end else begin
                        acc <= alu_res;
                        idx <= idx + 3'd1;
                        if (idx == 3'd4) begin
                            result <= alu_res;
                            flags  <= alu_flags;
                            err    <= 1'b0;
                            idx    <= '0;
                            state  <= ST_DONE;
                        end
                    end
                end
                default: begin
                    // IDLE and DONE both accept; DONE->RUN is the back-to-back path.
                    if (start) begin
                        lane_q[1] <= a_1;
                        lane_q[2] <= a_2;
                        lane_q[3] <= a_3;
                        lane_q[4] <= a_4;
                        op_q      <= op;
                        acc       <= a_0;
                        idx       <= 3'd1;
                        state     <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);
endmodule
